// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between NUM_PORTS workers.
// One transaction in flight at a time: grant, send, wait for response, return it.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_PORTS-1:0]   REQ_ADDR_VALID,
  input  logic [32*NUM_PORTS-1:0] REQ_ADDR,
  input  logic [NUM_PORTS-1:0]   REQ_DATA_VALID,
  input  logic [32*NUM_PORTS-1:0] REQ_DATA,
  output logic [NUM_PORTS-1:0]   REQ_READY,
  output logic [NUM_PORTS-1:0]   RSP_VALID,
  output logic [31:0]            RSP_DATA,
  input  logic [NUM_PORTS-1:0]   RSP_READY,
  output logic                   MEM_SEND_ADDR_VALID,
  output logic [31:0]            MEM_SEND_ADDR,
  output logic                   MEM_SEND_DATA_VALID,
  output logic [31:0]            MEM_SEND_DATA,
  input  logic                   MEM_SEND_READY,
  input  logic                   MEM_RECEIVE_VALID,
  input  logic [31:0]            MEM_RECEIVE_DATA,
  output logic                   MEM_RECEIVE_READY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [PTR_WIDTH:0]   NUM_PORTS_W = (PTR_WIDTH+1)'(NUM_PORTS);
  localparam logic [PTR_WIDTH-1:0] LAST_PORT   = PTR_WIDTH'(NUM_PORTS - 1);

  logic [1:0]           state_q, state_d;
  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_WIDTH-1:0] owner_q, owner_d;
  logic                 mem_send_addr_valid_q, mem_send_addr_valid_d;
  logic                 mem_send_data_valid_q, mem_send_data_valid_d;
  logic [31:0]          mem_send_addr_q, mem_send_addr_d;
  logic [31:0]          mem_send_data_q, mem_send_data_d;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;

  logic [31:0]          req_addr_a [NUM_PORTS];
  logic [31:0]          req_data_a [NUM_PORTS];
  logic                 grant_found;
  logic [PTR_WIDTH-1:0] grant_idx;
  logic [PTR_WIDTH:0]   cand;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_addr_a[p] = REQ_ADDR[32*p +: 32];
      req_data_a[p] = REQ_DATA[32*p +: 32];
    end
  end

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_WIDTH+1)'(i);
      if (cand >= NUM_PORTS_W) cand = cand - NUM_PORTS_W;
      if (!grant_found && REQ_ADDR_VALID[cand[PTR_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_WIDTH-1:0];
      end
    end
  end

  // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d               = state_q;
    rr_ptr_d              = rr_ptr_q;
    owner_d               = owner_q;
    mem_send_addr_valid_d = mem_send_addr_valid_q;
    mem_send_data_valid_d = mem_send_data_valid_q;
    mem_send_addr_d       = mem_send_addr_q;
    mem_send_data_d       = mem_send_data_q;
    rsp_valid_d           = rsp_valid_q;
    rsp_data_d            = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          mem_send_addr_d       = req_addr_a[grant_idx];
          mem_send_data_d       = req_data_a[grant_idx];
          mem_send_data_valid_d = REQ_DATA_VALID[grant_idx];
          mem_send_addr_valid_d = 1'b1;
          owner_d               = grant_idx;
          state_d               = S_SEND;
        end
      end
      S_SEND: begin
        if (MEM_SEND_READY) begin
          mem_send_addr_valid_d = 1'b0;
          mem_send_data_valid_d = 1'b0;
          state_d               = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MEM_RECEIVE_VALID) begin
          rsp_data_d  = MEM_RECEIVE_DATA;
          rsp_valid_d = NUM_PORTS'(1) << owner_q;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        // Only the owner's ready completes the handshake; others are ignored.
        if (RSP_READY[owner_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q               <= S_IDLE;
      rr_ptr_q              <= '0;
      owner_q               <= '0;
      mem_send_addr_valid_q <= 1'b0;
      mem_send_data_valid_q <= 1'b0;
      mem_send_addr_q       <= '0;
      mem_send_data_q       <= '0;
      rsp_valid_q           <= '0;
      rsp_data_q            <= '0;
    end else begin
      state_q               <= state_d;
      rr_ptr_q              <= rr_ptr_d;
      owner_q               <= owner_d;
      mem_send_addr_valid_q <= mem_send_addr_valid_d;
      mem_send_data_valid_q <= mem_send_data_valid_d;
      mem_send_addr_q       <= mem_send_addr_d;
      mem_send_data_q       <= mem_send_data_d;
      rsp_valid_q           <= rsp_valid_d;
      rsp_data_q            <= rsp_data_d;
    end
  end

  assign REQ_READY           = (state_q == S_IDLE && grant_found) ?
                               (NUM_PORTS'(1) << grant_idx) : '0;
  assign MEM_RECEIVE_READY   = (state_q == S_WAIT);
  assign MEM_SEND_ADDR_VALID = mem_send_addr_valid_q;
  assign MEM_SEND_ADDR       = mem_send_addr_q;
  assign MEM_SEND_DATA_VALID = mem_send_data_valid_q;
  assign MEM_SEND_DATA       = mem_send_data_q;
  assign RSP_VALID           = rsp_valid_q;
  assign RSP_DATA            = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, poke, round-robin,
// backpressure, stray responses and reset mid-transaction.
module tb_mem_port_arbiter;
  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_ADDR_VALID;
  logic [32*N-1:0] REQ_ADDR;
  logic [N-1:0]    REQ_DATA_VALID;
  logic [32*N-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic [N-1:0]    RSP_VALID;
  logic [31:0]     RSP_DATA;
  logic [N-1:0]    RSP_READY;
  logic            MEM_SEND_ADDR_VALID;
  logic [31:0]     MEM_SEND_ADDR;
  logic            MEM_SEND_DATA_VALID;
  logic [31:0]     MEM_SEND_DATA;
  logic            MEM_SEND_READY;
  logic            MEM_RECEIVE_VALID;
  logic [31:0]     MEM_RECEIVE_DATA;
  logic            MEM_RECEIVE_READY;

  mem_port_arbiter #(.NUM_PORTS(N), .PTR_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_ADDR_VALID(REQ_ADDR_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .RSP_READY(RSP_READY),
    .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_ADDR(MEM_SEND_ADDR),
    .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID), .MEM_SEND_DATA(MEM_SEND_DATA),
    .MEM_SEND_READY(MEM_SEND_READY),
    .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
    .MEM_RECEIVE_READY(MEM_RECEIVE_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_tbl [N];
  logic [31:0] data_tbl [N];
  logic        dv_tbl   [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int port, input logic [31:0] addr,
                         input logic [31:0] data, input logic dv);
    addr_tbl[port]             = addr;
    data_tbl[port]             = data;
    dv_tbl[port]               = dv;
    REQ_ADDR[32*port +: 32]    = addr;
    REQ_DATA[32*port +: 32]    = data;
    REQ_DATA_VALID[port]       = dv;
    REQ_ADDR_VALID[port]       = 1'b1;
  endtask

  // Zero-wait transaction starting in S_IDLE with the request already driven.
  task automatic run_txn(input int port, input logic [31:0] rdata,
                         input bit hold, input string tag);
    #1;
    check({tag, " req_ready c0"}, 32'(REQ_READY), 32'(1 << port));
    step();
    if (!hold) REQ_ADDR_VALID[port] = 1'b0;
    check({tag, " addr_valid c1"}, 32'(MEM_SEND_ADDR_VALID), 32'd1);
    check({tag, " addr c1"}, MEM_SEND_ADDR, addr_tbl[port]);
    check({tag, " data_valid c1"}, 32'(MEM_SEND_DATA_VALID), 32'(dv_tbl[port]));
    if (dv_tbl[port]) check({tag, " data c1"}, MEM_SEND_DATA, data_tbl[port]);
    step();
    check({tag, " recv_ready c2"}, 32'(MEM_RECEIVE_READY), 32'd1);
    MEM_RECEIVE_VALID = 1'b1;
    MEM_RECEIVE_DATA  = rdata;
    step();
    MEM_RECEIVE_VALID = 1'b0;
    check({tag, " rsp_valid c3"}, 32'(RSP_VALID), 32'(1 << port));
    check({tag, " rsp_data c3"}, RSP_DATA, rdata);
    step();
    check({tag, " rsp_valid c4"}, 32'(RSP_VALID), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " addr_valid"}, 32'(MEM_SEND_ADDR_VALID), 32'd0);
    check({tag, " addr"}, MEM_SEND_ADDR, 32'd0);
    check({tag, " data_valid"}, 32'(MEM_SEND_DATA_VALID), 32'd0);
    check({tag, " data"}, MEM_SEND_DATA, 32'd0);
    check({tag, " rsp_valid"}, 32'(RSP_VALID), 32'd0);
    check({tag, " rsp_data"}, RSP_DATA, 32'd0);
    check({tag, " recv_ready"}, 32'(MEM_RECEIVE_READY), 32'd0);
    check({tag, " req_ready"}, 32'(REQ_READY), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    REQ_ADDR_VALID = '0; REQ_ADDR = '0; REQ_DATA_VALID = '0; REQ_DATA = '0;
    RSP_READY = '1; MEM_SEND_READY = 1'b1;
    MEM_RECEIVE_VALID = 1'b0; MEM_RECEIVE_DATA = '0;
    step();
    step();
    RST = 1'b0;
    check_all_zero("reset");

    // Single peek from port 2 with exact cycle latency.
    set_req(2, 32'h100, 32'h0, 1'b0);
    run_txn(2, 32'hDEADBEEF, 1'b0, "peek");
    check("peek rsp_data hold", RSP_DATA, 32'hDEADBEEF);

    // Round-robin from a clean pointer: all four request continuously.
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int p = 0; p < N; p++) set_req(p, 32'h1000 + 32'(16 * p), 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) run_txn(k % N, 32'hA0 + 32'(k), 1'b1, $sformatf("rr%0d", k));
    REQ_ADDR_VALID = '0;

    // Stray response in S_IDLE.
    MEM_RECEIVE_VALID = 1'b1;
    MEM_RECEIVE_DATA  = 32'hBAD;
    #1;
    check("stray idle recv_ready", 32'(MEM_RECEIVE_READY), 32'd0);
    check("stray idle req_ready", 32'(REQ_READY), 32'd0);
    step();
    MEM_RECEIVE_VALID = 1'b0;
    check("stray idle rsp_valid", 32'(RSP_VALID), 32'd0);
    check("stray idle rsp_data", RSP_DATA, 32'hA5);
    check("stray idle addr_valid", 32'(MEM_SEND_ADDR_VALID), 32'd0);

    // Poke from port 0 with send backpressure and a stray response in S_SEND.
    MEM_SEND_READY = 1'b0;
    set_req(0, 32'h20, 32'h55, 1'b1);
    #1;
    check("poke req_ready", 32'(REQ_READY), 32'h1);
    step();
    REQ_ADDR_VALID[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("poke bp%0d addr_valid", i), 32'(MEM_SEND_ADDR_VALID), 32'd1);
      check($sformatf("poke bp%0d addr", i), MEM_SEND_ADDR, 32'h20);
      check($sformatf("poke bp%0d data_valid", i), 32'(MEM_SEND_DATA_VALID), 32'd1);
      check($sformatf("poke bp%0d data", i), MEM_SEND_DATA, 32'h55);
      check($sformatf("poke bp%0d recv_ready", i), 32'(MEM_RECEIVE_READY), 32'd0);
      MEM_RECEIVE_VALID = (i == 2);
      step();
    end
    check("stray send rsp_valid", 32'(RSP_VALID), 32'd0);
    MEM_SEND_READY    = 1'b1;
    MEM_RECEIVE_VALID = 1'b1;
    MEM_RECEIVE_DATA  = 32'h77;
    step();
    check("poke wait addr_valid", 32'(MEM_SEND_ADDR_VALID), 32'd0);
    check("poke wait data_valid", 32'(MEM_SEND_DATA_VALID), 32'd0);
    check("poke simul rsp_valid", 32'(RSP_VALID), 32'd0);
    check("poke wait recv_ready", 32'(MEM_RECEIVE_READY), 32'd1);
    step();
    MEM_RECEIVE_VALID = 1'b0;
    check("poke rsp_valid", 32'(RSP_VALID), 32'h1);
    check("poke rsp_data", RSP_DATA, 32'h77);
    step();
    check("poke rsp done", 32'(RSP_VALID), 32'd0);
    check("poke rsp_data hold", RSP_DATA, 32'h77);

    // Response backpressure on port 1 while port 2 waits.
    RSP_READY = 4'b1101;
    set_req(1, 32'h300, 32'h0, 1'b0);
    set_req(2, 32'h400, 32'h9, 1'b1);
    #1;
    check("rspbp req_ready", 32'(REQ_READY), 32'h2);
    step();
    REQ_ADDR_VALID[1] = 1'b0;
    check("rspbp addr", MEM_SEND_ADDR, 32'h300);
    step();
    MEM_RECEIVE_VALID = 1'b1;
    MEM_RECEIVE_DATA  = 32'h1111;
    step();
    MEM_RECEIVE_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rspbp%0d rsp_valid", i), 32'(RSP_VALID), 32'h2);
      check($sformatf("rspbp%0d req_ready", i), 32'(REQ_READY), 32'd0);
      check($sformatf("rspbp%0d rsp_data", i), RSP_DATA, 32'h1111);
      step();
    end
    RSP_READY = '1;
    check("rspbp last rsp_valid", 32'(RSP_VALID), 32'h2);
    step();
    check("rspbp released", 32'(RSP_VALID), 32'd0);
    #1;
    check("rspbp next grant", 32'(REQ_READY), 32'h4);

    // Port 2 reaches S_WAIT, then reset abandons it.
    step();
    REQ_ADDR_VALID[2] = 1'b0;
    check("rst pre addr", MEM_SEND_ADDR, 32'h400);
    check("rst pre data", MEM_SEND_DATA, 32'h9);
    step();
    check("rst pre recv_ready", 32'(MEM_RECEIVE_READY), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_all_zero("rst wait");
    set_req(0, 32'h500, 32'h0, 1'b0);
    set_req(3, 32'h600, 32'h0, 1'b0);
    run_txn(0, 32'hCAFE, 1'b0, "post rst");
    REQ_ADDR_VALID = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
